// File: rtl/page_req_arb_pkg.sv
// Shared linked-list defines used by the page request arbiter and the free-list side.
// Holds the page address width, the port limit and the grant-tag width helper.
package page_req_arb_pkg;

  localparam int LL_PG_ASZ     = 12;
  localparam int PRA_MAX_PORTS = 8;

  // Width of a port index carried in the tag queue.
  function automatic int pra_tag_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/page_arb_tagq.sv
// Grant-order tag FIFO: records which allocator each outstanding page request belongs to.
// Full/empty are flops; head is read from the registered read pointer, so there is no push-to-pop bypass.
module page_arb_tagq #(
  parameter int depth = 8,
  parameter int tag_w = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [tag_w-1:0] push_tag,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [tag_w-1:0] head
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(depth);

  logic [tag_w-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             push_ok, pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)
      count_nxt = count + (AW+1)'(1);
    else if (!push_ok && pop_ok)
      count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

  // Storage carries no reset; stale entries are never visible while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/page_req_arb.sv
// Round-robin merge of allocator page requests onto the free-list request channel,
// with returned pages steered back to the requester in grant order.
module page_req_arb
  import page_req_arb_pkg::*;
#(
  parameter int ports = 4,
  parameter int depth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ports-1:0]     req_srdy,
  output logic [ports-1:0]     req_drdy,
  output logic [ports-1:0]     rsp_srdy,
  input  logic [ports-1:0]     rsp_drdy,
  output logic [LL_PG_ASZ-1:0] rsp_page,
  output logic                 fl_req_srdy,
  input  logic                 fl_req_drdy,
  input  logic                 fl_rsp_srdy,
  output logic                 fl_rsp_drdy,
  input  logic [LL_PG_ASZ-1:0] fl_rsp_page
);

  localparam int TW = pra_tag_w(ports);

  logic [TW-1:0] rr_ptr, gnt, head;
  logic          gnt_vld, full, empty, push, pop;

  // First requester at or above rr_ptr, wrapping modulo ports.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt     = rr_ptr;
    for (int i = 0; i < ports; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= ports) idx = idx - ports;
      if (!gnt_vld && req_srdy[idx]) begin
        gnt_vld = 1'b1;
        gnt     = TW'(idx);
      end
    end
  end

  assign fl_req_srdy = (|req_srdy) & ~full;
  assign push        = fl_req_srdy & fl_req_drdy;

  always_comb begin
    req_drdy = '0;
    if (gnt_vld && fl_req_drdy && !full) req_drdy[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (push)
      rr_ptr <= (gnt == TW'(ports-1)) ? '0 : gnt + TW'(1);
  end

  // A page arriving with nothing outstanding is left upstream: no steer, no accept.
  always_comb begin
    rsp_srdy = '0;
    if (fl_rsp_srdy && !empty) rsp_srdy[head] = 1'b1;
  end

  assign fl_rsp_drdy = rsp_drdy[head] & ~empty;
  assign pop         = fl_rsp_srdy & fl_rsp_drdy;
  assign rsp_page    = fl_rsp_page;

  page_arb_tagq #(
    .depth (depth),
    .tag_w (TW)
  ) u_tagq (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_tag (gnt),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

endmodule
